// File: rtl/max_score_tracker_pkg.sv
// Shared types and constants for max_score_tracker: configuration values,
// the tracker FSM state enum, the inter-stage candidate payload and the
// candidate-compare helper used by every max stage.
package max_score_tracker_pkg;

  localparam int unsigned NUM_PU             = 4;
  localparam int unsigned NUM_ROWS_PE        = 2;
  localparam int unsigned NUM_COLS_PE        = 2;
  localparam int unsigned SCORE_WIDTH        = 10;
  localparam int unsigned SEQ_LENGTH_W       = 6;
  localparam int unsigned NUM_PE             = NUM_ROWS_PE * NUM_COLS_PE;
  localparam int unsigned TRACKER_PIPE_DEPTH = 3;
  localparam int unsigned DRAIN_CNT_W        = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } tracker_state_t;

  typedef struct packed {
    logic [SCORE_WIDTH-1:0]  score;
    logic [SEQ_LENGTH_W-1:0] row;
    logic [SEQ_LENGTH_W-1:0] col;
    logic                    valid;
  } cand_t;

  // True when candidate a should replace the current best b; equal scores
  // never replace, so the earlier (lower-index) candidate keeps the tie.
  function automatic logic cand_beats(input cand_t a, input cand_t b);
    return a.valid && (!b.valid || (a.score > b.score));
  endfunction

endpackage

// File: rtl/max_score_tracker_max_cand_select.sv
// max_cand_select: combinational N-way maximum over score candidates.
// Invalid candidates are skipped; ties resolve to the lowest index.
// With no valid candidate the result is all-zero (score 0, invalid).
module max_cand_select
  import max_score_tracker_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  cand_t [N-1:0] cands,
  output cand_t         best_c
);

  // Linear scan from index 0 so the lowest index wins on equal scores
  always_comb begin
    best_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (cand_beats(cands[i], best_c)) begin
        best_c = cands[i];
      end
    end
  end

endmodule

// File: rtl/max_score_tracker.sv
// max_score_tracker: tracks the running maximum PE score of one alignment
// and its matrix coordinates through a 3-deep pipeline
// (input capture -> per-PU max -> cross-PU max -> running-max update).
// Optional feature macro: MAX_SCORE_TRACKER_THRESHOLD_EN adds a sticky
// above_threshold flag against a threshold sampled at start.
module max_score_tracker
  import max_score_tracker_pkg::*;
(
  input  logic                                                            clk,
  input  logic                                                            rst,
  input  logic                                                            start,
  input  logic [NUM_PU-1:0][NUM_ROWS_PE-1:0][NUM_COLS_PE-1:0][SCORE_WIDTH-1:0] scores_in,
  input  logic [NUM_PU-1:0]                                               pu_valid,
  input  logic [NUM_PU-1:0][SEQ_LENGTH_W-1:0]                             pu_row_base,
  input  logic [NUM_PU-1:0][SEQ_LENGTH_W-1:0]                             pu_col_base,
  input  logic                                                            last,
  output logic                                                            busy,
  output logic                                                            result_valid,
  output logic [SCORE_WIDTH-1:0]                                          max_score,
  output logic [SEQ_LENGTH_W-1:0]                                         max_row,
  output logic [SEQ_LENGTH_W-1:0]                                         max_col
`ifdef MAX_SCORE_TRACKER_THRESHOLD_EN
  ,
  input  logic [SCORE_WIDTH-1:0]                                          score_threshold,
  output logic                                                            above_threshold
`endif
);

  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(TRACKER_PIPE_DEPTH - 1);

  tracker_state_t          state_q, state_d;
  logic [DRAIN_CNT_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic                    busy_d, result_valid_d;
  logic                    sample_c;

  logic [NUM_PU-1:0]                                               in_valid_q;
  logic [NUM_PU-1:0][NUM_ROWS_PE-1:0][NUM_COLS_PE-1:0][SCORE_WIDTH-1:0] in_scores_q;
  logic [NUM_PU-1:0][SEQ_LENGTH_W-1:0]                             in_row_q;
  logic [NUM_PU-1:0][SEQ_LENGTH_W-1:0]                             in_col_q;

  cand_t [NUM_PU-1:0] pu_best_c;
  cand_t [NUM_PU-1:0] s1_q;
  cand_t              all_best_c;
  cand_t              s2_q;
  logic               update_c;

  // Beats are taken only in TRACK; a start in the same cycle discards them
  assign sample_c = (state_q == ST_TRACK) && !start;

  // FSM state register and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      drain_cnt_q  <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_cnt_q  <= drain_cnt_d;
      busy         <= busy_d;
      result_valid <= result_valid_d;
    end
  end

  // Next-state logic; start overrides every state, including a same-cycle last
  always_comb begin
    state_d        = state_q;
    drain_cnt_d    = drain_cnt_q;
    busy_d         = 1'b0;
    result_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: ;
      ST_TRACK: begin
        if (last) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = ST_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + DRAIN_CNT_W'(1);
        end
      end
      ST_DONE: ;
      default: state_d = ST_IDLE;
    endcase
    if (start) begin
      state_d     = ST_TRACK;
      drain_cnt_d = '0;
    end
    busy_d         = (state_d == ST_TRACK) || (state_d == ST_DRAIN);
    result_valid_d = (state_d == ST_DONE);
  end

  // Pipeline stage 0: capture the qualified score beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_valid_q  <= '0;
      in_scores_q <= '0;
      in_row_q    <= '0;
      in_col_q    <= '0;
    end else begin
      in_valid_q <= sample_c ? pu_valid : '0;
      if (sample_c) begin
        in_scores_q <= scores_in;
        in_row_q    <= pu_row_base;
        in_col_q    <= pu_col_base;
      end
    end
  end

  // Stage 1 combinational: per-PU max over its PE block
  for (genvar p = 0; p < NUM_PU; p++) begin : g_pu
    cand_t [NUM_PE-1:0] pe_cands;
    for (genvar r = 0; r < NUM_ROWS_PE; r++) begin : g_row
      for (genvar c = 0; c < NUM_COLS_PE; c++) begin : g_col
        assign pe_cands[r*NUM_COLS_PE + c] = '{
          score: in_scores_q[p][r][c],
          row:   in_row_q[p] + SEQ_LENGTH_W'(r),
          col:   in_col_q[p] + SEQ_LENGTH_W'(c),
          valid: in_valid_q[p]
        };
      end
    end
    max_cand_select #(.N(NUM_PE)) u_pe_max (
      .cands  (pe_cands),
      .best_c (pu_best_c[p])
    );
  end

  // Stage 2 combinational: max across PU winners
  max_cand_select #(.N(NUM_PU)) u_pu_max (
    .cands  (s1_q),
    .best_c (all_best_c)
  );

  // Stage 1/2 registers; start flushes any in-flight beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else if (start) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= pu_best_c;
      s2_q <= all_best_c;
    end
  end

  // Strictly-greater update keeps the earliest occurrence of a value
  assign update_c = s2_q.valid && (s2_q.score > max_score);

  // Stage 3: running maximum and its coordinates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_score <= '0;
      max_row   <= '0;
      max_col   <= '0;
    end else if (start) begin
      max_score <= '0;
      max_row   <= '0;
      max_col   <= '0;
    end else if (update_c) begin
      max_score <= s2_q.score;
      max_row   <= s2_q.row;
      max_col   <= s2_q.col;
    end
  end

`ifdef MAX_SCORE_TRACKER_THRESHOLD_EN
  logic [SCORE_WIDTH-1:0] threshold_q;

  // Sticky flag set on the edge the running max reaches the sampled threshold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      threshold_q     <= '0;
      above_threshold <= 1'b0;
    end else if (start) begin
      threshold_q     <= score_threshold;
      above_threshold <= 1'b0;
    end else if (update_c && (s2_q.score >= threshold_q)) begin
      above_threshold <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_max_score_tracker.sv
// Directed bench for max_score_tracker with hand-computed expectations.
// Threshold checks run only when MAX_SCORE_TRACKER_THRESHOLD_EN is defined.
module tb_max_score_tracker;
  import max_score_tracker_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic last;
  logic [NUM_PU-1:0][NUM_ROWS_PE-1:0][NUM_COLS_PE-1:0][SCORE_WIDTH-1:0] scores_in;
  logic [NUM_PU-1:0]                   pu_valid;
  logic [NUM_PU-1:0][SEQ_LENGTH_W-1:0] pu_row_base;
  logic [NUM_PU-1:0][SEQ_LENGTH_W-1:0] pu_col_base;
  logic                                busy;
  logic                                result_valid;
  logic [SCORE_WIDTH-1:0]              max_score;
  logic [SEQ_LENGTH_W-1:0]             max_row;
  logic [SEQ_LENGTH_W-1:0]             max_col;
`ifdef MAX_SCORE_TRACKER_THRESHOLD_EN
  logic [SCORE_WIDTH-1:0]              score_threshold;
  logic                                above_threshold;
`endif

  int vectors     = 0;
  int miscompares = 0;

  max_score_tracker dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .scores_in       (scores_in),
    .pu_valid        (pu_valid),
    .pu_row_base     (pu_row_base),
    .pu_col_base     (pu_col_base),
    .last            (last),
    .busy            (busy),
    .result_valid    (result_valid),
    .max_score       (max_score),
    .max_row         (max_row),
    .max_col         (max_col)
`ifdef MAX_SCORE_TRACKER_THRESHOLD_EN
    ,
    .score_threshold (score_threshold),
    .above_threshold (above_threshold)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_max(input string tag, input int s, input int r, input int c);
    check({tag, "_score"}, 32'(max_score), 32'(s));
    check({tag, "_row"},   32'(max_row),   32'(r));
    check({tag, "_col"},   32'(max_col),   32'(c));
  endtask

  task automatic clear_beat();
    pu_valid    = '0;
    scores_in   = '0;
    pu_row_base = '0;
    pu_col_base = '0;
    last        = 1'b0;
  endtask

  task automatic set_pe(input int p, input int r, input int c, input int s, input int rb, input int cb);
    scores_in[p][r][c] = SCORE_WIDTH'(s);
    pu_row_base[p]     = SEQ_LENGTH_W'(rb);
    pu_col_base[p]     = SEQ_LENGTH_W'(cb);
    pu_valid[p]        = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    clear_beat();
`ifdef MAX_SCORE_TRACKER_THRESHOLD_EN
    score_threshold = '0;
`endif
    repeat (2) step();
    check("rst_busy", 32'(busy), 0);
    check("rst_rv", 32'(result_valid), 0);
    check_max("rst", 0, 0, 0);
    rst = 1'b0;
    step();

    // Single beat, last on the following cycle
    pulse_start();
    check("t1_busy_start", 32'(busy), 1);
    set_pe(1, 1, 0, 37, 4, 6);
    step();
    clear_beat(); last = 1'b1;
    step();
    last = 1'b0;
    check("t1_max_early", 32'(max_score), 0);
    step();
    check("t1_rv_early", 32'(result_valid), 0);
    step();
    check_max("t1_upd", 37, 5, 6);
    check("t1_rv_drain", 32'(result_valid), 0);
    check("t1_busy_drain", 32'(busy), 1);
    step();
    check("t1_rv", 32'(result_valid), 1);
    check("t1_busy_fall", 32'(busy), 0);
    step();
    check_max("t1_hold", 37, 5, 6);
    check("t1_rv_hold", 32'(result_valid), 1);

    // Tie handling: PE index, PU index, later equal, later greater
    pulse_start();
    check("t2_rv_clr", 32'(result_valid), 0);
    check_max("t2_clr", 0, 0, 0);
    set_pe(0, 0, 1, 20, 0, 0);
    set_pe(0, 1, 0, 20, 0, 0);
    set_pe(2, 0, 0, 20, 10, 20);
    step();
    clear_beat(); set_pe(3, 1, 1, 20, 30, 30);
    step();
    clear_beat(); set_pe(1, 0, 0, 21, 8, 9); last = 1'b1;
    step();
    clear_beat();
    step();
    check_max("t2_tie", 20, 0, 1);
    step();
    check_max("t2_equal", 20, 0, 1);
    step();
    check_max("t2_greater", 21, 8, 9);
    check("t2_rv", 32'(result_valid), 1);

    // Invalid PU carrying a large score is ignored
    pulse_start();
    set_pe(0, 1, 1, 40, 2, 3);
    scores_in[1][0][0] = SCORE_WIDTH'(500);
    pu_row_base[1] = SEQ_LENGTH_W'(9);
    last = 1'b1;
    step();
    clear_beat();
    repeat (2) step();
    check("t3_rv_early", 32'(result_valid), 0);
    step();
    check_max("t3_valid_only", 40, 3, 4);
    check("t3_rv", 32'(result_valid), 1);

    // Abort by start two cycles after a beat
    pulse_start();
    set_pe(2, 0, 0, 99, 1, 1);
    step();
    clear_beat();
    step();
    pulse_start();
    check("t4_busy_abort", 32'(busy), 1);
    check("t4_max_clr", 32'(max_score), 0);
    repeat (2) step();
    check_max("t4_flushed", 0, 0, 0);
    check("t4_busy_keep", 32'(busy), 1);
    // start together with last restarts rather than terminating
    start = 1'b1; last = 1'b1;
    step();
    start = 1'b0; last = 1'b0;
    repeat (4) step();
    check("t4_sl_busy", 32'(busy), 1);
    check("t4_sl_rv", 32'(result_valid), 0);
    // All-zero alignment
    pu_valid = '1; last = 1'b1;
    step();
    clear_beat();
    repeat (3) step();
    check("t4_zero_rv", 32'(result_valid), 1);
    check_max("t4_zero", 0, 0, 0);

    // Asynchronous reset during DRAIN, then normal recovery
    pulse_start();
    set_pe(3, 0, 1, 77, 5, 5);
    step();
    clear_beat();
    repeat (2) step();
    last = 1'b1;
    step();
    last = 1'b0;
    check_max("t5_pre", 77, 5, 6);
    check("t5_busy_drain", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_rv", 32'(result_valid), 0);
    check_max("t5_rst", 0, 0, 0);
    step();
    rst = 1'b0;
    step();
    check("t5_idle_busy", 32'(busy), 0);
    pulse_start();
    set_pe(3, 1, 0, 12, 7, 8); last = 1'b1;
    step();
    clear_beat();
    repeat (3) step();
    check_max("t5_recover", 12, 8, 8);
    check("t5_recover_rv", 32'(result_valid), 1);
    check("t5_recover_busy", 32'(busy), 0);

`ifdef MAX_SCORE_TRACKER_THRESHOLD_EN
    // Threshold sampled at start, sticky until next start
    score_threshold = SCORE_WIDTH'(50);
    pulse_start();
    score_threshold = '0;
    check("t6_thr_clr", 32'(above_threshold), 0);
    set_pe(0, 0, 0, 30, 0, 0);
    step();
    clear_beat(); set_pe(0, 0, 0, 55, 1, 1);
    step();
    clear_beat(); set_pe(0, 0, 0, 10, 2, 2); last = 1'b1;
    step();
    clear_beat();
    step();
    check("t6_thr_below", 32'(above_threshold), 0);
    check("t6_max30", 32'(max_score), 30);
    step();
    check("t6_thr_rise", 32'(above_threshold), 1);
    check_max("t6_max55", 55, 1, 1);
    step();
    check("t6_thr_done", 32'(above_threshold), 1);
    check("t6_rv", 32'(result_valid), 1);
    step();
    check("t6_thr_hold", 32'(above_threshold), 1);
    pulse_start();
    check("t6_thr_start_clr", 32'(above_threshold), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
